hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, Clk; reset Rst SHALL be synchronous and active-high.
REQ-002 Parameter ADDR_W, default 64, SHALL set the jump address width.
REQ-003 Parameter REG_AW, default 5, SHALL set the register-address width.
REQ-004 Parameter CNT_W, default 32, SHALL set the performance-counter width.
REQ-005 Parameter MEM_TIMEOUT, default 256, SHALL set the memory-wait cycle limit that raises a timeout.
REQ-006 Ports SHALL be as follows (name, direction, width, meaning):
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
IdRs1Addr  in  REG_AW  rs1 of the instruction in decode
IdRs1Ren  in  1  rs1 read enable
IdRs2Addr  in  REG_AW  rs2 of the instruction in decode
IdRs2Ren  in  1  rs2 read enable
ExRdAddr  in  REG_AW  rd of the instruction in execute
ExRdWen  in  1  rd write enable in execute
ExIsLoad  in  1  instruction in execute is a load
ExJumpFlag  in  1  execute resolved a taken jump or branch
ExJumpAddr  in  ADDR_W  jump target
MemReq  in  1  memory stage has an access outstanding
MemAck  in  1  memory access completes this cycle
PcHold  out  1  freeze PC
If2IdHold  out  1  freeze IF/ID register
Id2ExHold  out  1  freeze ID/EX register
Ex2MemHold  out  1  freeze EX/MEM register
If2IdFlush  out  1  load a bubble into IF/ID
Id2ExFlush  out  1  load a bubble into ID/EX
Mem2WbFlush  out  1  load a bubble into MEM/WB
JumpFlagToPc  out  1  redirect PC
JumpAddrToPc  out  ADDR_W  redirect target
MemTimeout  out  1  sticky memory-wait timeout
StallCnt  out  CNT_W  count of PcHold cycles
JumpCnt  out  CNT_W  count of taken redirects

Function
REQ-007 The load-use term LU SHALL be: ExIsLoad & ExRdWen & (ExRdAddr != 0) & ((IdRs1Ren & IdRs1Addr == ExRdAddr) | (IdRs2Ren & IdRs2Addr == ExRdAddr)).
REQ-008 The memory-wait term MW SHALL be MemReq & !MemAck.
REQ-009 The FSM SHALL have two states, RUN and MEM_WAIT; outputs SHALL be combinational from state and inputs.
REQ-010 Evaluation SHALL follow priority MW > ExJumpFlag > LU; only the highest-priority active term takes effect.
REQ-011 When MW=1 (either state): PcHold, If2IdHold, Id2ExHold, Ex2MemHold and Mem2WbFlush SHALL be 1; all other controls SHALL be 0; next state SHALL be MEM_WAIT.
REQ-012 When MW=0 and ExJumpFlag=1:
- JumpFlagToPc=1 and JumpAddrToPc=ExJumpAddr;
- If2IdFlush=1 and Id2ExFlush=1;
- no holds asserted;
- JumpCnt increments.
REQ-013 When MW=0, ExJumpFlag=0 and LU=1: PcHold=1, If2IdHold=1 and Id2ExFlush=1, giving a one-cycle bubble.
REQ-014 MEM_WAIT with MemAck=1 SHALL behave as RUN with MW=0, and next state SHALL be RUN.
REQ-015 Outside a redirect, JumpAddrToPc SHALL be 0.
REQ-016 A wait counter SHALL clear in RUN and increment each MEM_WAIT cycle; when it reaches MEM_TIMEOUT, MemTimeout SHALL set and stay set until Rst; stalling SHALL continue.
REQ-017 StallCnt SHALL increment every cycle PcHold=1.
REQ-018 StallCnt and JumpCnt SHALL saturate at all-ones and never wrap.

Reset
REQ-019 While Rst=1, all control outputs and JumpAddrToPc SHALL be 0 regardless of inputs.
REQ-020 Rst SHALL set state=RUN and clear both counters, the wait counter and MemTimeout on the next edge, including mid-MEM_WAIT.

Structure
REQ-021 Package hazard_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT) and the default REG_AW/CNT_W constants.
REQ-022 Sub-module sat_counter (width-parametrised, synchronous clear, increment enable, saturating) SHALL be instantiated for StallCnt and JumpCnt.

Verification
REQ-023 ExIsLoad=1, ExRdWen=1, ExRdAddr=5, IdRs1Ren=1, IdRs1Addr=5 for one cycle -> PcHold=1, If2IdHold=1, Id2ExFlush=1, StallCnt 0->1; the same stimulus with ExRdAddr=0 -> no stall.
REQ-024 ExJumpFlag=1 with ExJumpAddr=0x80000010 in the same cycle as a load-use match -> JumpFlagToPc=1, JumpAddrToPc=0x80000010, If2IdFlush=1, Id2ExFlush=1, PcHold=0, JumpCnt +1.
REQ-025 MemReq=1, MemAck=0 for 3 cycles, then MemAck=1 -> all four holds and Mem2WbFlush=1 for 3 cycles, all 0 on the ack cycle, state back to RUN, StallCnt +3.
REQ-026 MEM_TIMEOUT=4 with MemReq=1, MemAck=0 held for 6 cycles -> MemTimeout rises after the 4th MEM_WAIT cycle and stays 1 after the ack, until Rst.
REQ-027 Rst=1 asserted during MEM_WAIT -> same-cycle outputs 0; next cycle state=RUN, StallCnt=0, JumpCnt=0, MemTimeout=0.
REQ-028 CNT_W=4 with 20 load-use stalls -> StallCnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, jump redirects and load-use
// bubbles, with a sticky memory timeout and saturating stall/jump counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 256
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] IdRs1Addr,
  input  logic              IdRs1Ren,
  input  logic [REG_AW-1:0] IdRs2Addr,
  input  logic              IdRs2Ren,
  input  logic [REG_AW-1:0] ExRdAddr,
  input  logic              ExRdWen,
  input  logic              ExIsLoad,
  input  logic              ExJumpFlag,
  input  logic [ADDR_W-1:0] ExJumpAddr,
  input  logic              MemReq,
  input  logic              MemAck,
  output logic              PcHold,
  output logic              If2IdHold,
  output logic              Id2ExHold,
  output logic              Ex2MemHold,
  output logic              If2IdFlush,
  output logic              Id2ExFlush,
  output logic              Mem2WbFlush,
  output logic              JumpFlagToPc,
  output logic [ADDR_W-1:0] JumpAddrToPc,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  JumpCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              lu;
  logic              mw;

  assign lu = ExIsLoad & ExRdWen & (ExRdAddr != '0) &
              ((IdRs1Ren & (IdRs1Addr == ExRdAddr)) |
               (IdRs2Ren & (IdRs2Addr == ExRdAddr)));
  assign mw = MemReq & ~MemAck;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    PcHold       = 1'b0;
    If2IdHold    = 1'b0;
    Id2ExHold    = 1'b0;
    Ex2MemHold   = 1'b0;
    If2IdFlush   = 1'b0;
    Id2ExFlush   = 1'b0;
    Mem2WbFlush  = 1'b0;
    JumpFlagToPc = 1'b0;
    JumpAddrToPc = '0;

    // Priority: memory wait beats a redirect, which beats a load-use bubble.
    if (mw) begin
      PcHold      = 1'b1;
      If2IdHold   = 1'b1;
      Id2ExHold   = 1'b1;
      Ex2MemHold  = 1'b1;
      Mem2WbFlush = 1'b1;
      state_d     = MEM_WAIT;
    end else begin
      state_d = RUN;
      if (ExJumpFlag) begin
        JumpFlagToPc = 1'b1;
        JumpAddrToPc = ExJumpAddr;
        If2IdFlush   = 1'b1;
        Id2ExFlush   = 1'b1;
      end else if (lu) begin
        PcHold     = 1'b1;
        If2IdHold  = 1'b1;
        Id2ExFlush = 1'b1;
      end
    end

    // Wait counter parks at the limit so the timeout flag stays meaningful.
    if (state_q == MEM_WAIT) begin
      if (wait_q != TIMEOUT_V) begin
        wait_d = wait_q + 1'b1;
      end
      if (wait_d == TIMEOUT_V) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_d = '0;
    end

    if (Rst) begin
      PcHold       = 1'b0;
      If2IdHold    = 1'b0;
      Id2ExHold    = 1'b0;
      Ex2MemHold   = 1'b0;
      If2IdFlush   = 1'b0;
      Id2ExFlush   = 1'b0;
      Mem2WbFlush  = 1'b0;
      JumpFlagToPc = 1'b0;
      JumpAddrToPc = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign MemTimeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (Clk),
    .clr (Rst),
    .inc (PcHold),
    .cnt (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_jump_cnt (
    .clk (Clk),
    .clr (Rst),
    .inc (JumpFlagToPc),
    .cnt (JumpCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a small instance
// (MEM_TIMEOUT=4, CNT_W=4) sharing the same stimulus.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_ren, id_rs2_ren, ex_rd_wen, ex_is_load, ex_jump_flag;
  logic [63:0] ex_jump_addr;
  logic        mem_req, mem_ack;

  logic        pc_hold, if2id_hold, id2ex_hold, ex2mem_hold;
  logic        if2id_flush, id2ex_flush, mem2wb_flush, jump_flag_to_pc;
  logic [63:0] jump_addr_to_pc;
  logic        mem_timeout;
  logic [31:0] stall_cnt, jump_cnt;

  logic        s_pc_hold, s_if2id_hold, s_id2ex_hold, s_ex2mem_hold;
  logic        s_if2id_flush, s_id2ex_flush, s_mem2wb_flush, s_jump_flag_to_pc;
  logic [63:0] s_jump_addr_to_pc;
  logic        s_mem_timeout;
  logic [3:0]  s_stall_cnt, s_jump_cnt;

  logic [7:0]  ctl, s_ctl;
  int          total;
  int          bad;
  int          exp_stall;
  int          exp_jump;

  // ctl bits: PcHold, If2IdHold, Id2ExHold, Ex2MemHold, If2IdFlush, Id2ExFlush, Mem2WbFlush, JumpFlagToPc
  localparam logic [7:0] CTL_NONE = 8'b0000_0000;
  localparam logic [7:0] CTL_LU   = 8'b1100_0100;
  localparam logic [7:0] CTL_JUMP = 8'b0000_1101;
  localparam logic [7:0] CTL_MW   = 8'b1111_0010;

  assign ctl   = {pc_hold, if2id_hold, id2ex_hold, ex2mem_hold,
                  if2id_flush, id2ex_flush, mem2wb_flush, jump_flag_to_pc};
  assign s_ctl = {s_pc_hold, s_if2id_hold, s_id2ex_hold, s_ex2mem_hold,
                  s_if2id_flush, s_id2ex_flush, s_mem2wb_flush, s_jump_flag_to_pc};

  hazard_ctrl dut (
    .Clk(clk), .Rst(rst),
    .IdRs1Addr(id_rs1_addr), .IdRs1Ren(id_rs1_ren),
    .IdRs2Addr(id_rs2_addr), .IdRs2Ren(id_rs2_ren),
    .ExRdAddr(ex_rd_addr), .ExRdWen(ex_rd_wen), .ExIsLoad(ex_is_load),
    .ExJumpFlag(ex_jump_flag), .ExJumpAddr(ex_jump_addr),
    .MemReq(mem_req), .MemAck(mem_ack),
    .PcHold(pc_hold), .If2IdHold(if2id_hold), .Id2ExHold(id2ex_hold),
    .Ex2MemHold(ex2mem_hold), .If2IdFlush(if2id_flush), .Id2ExFlush(id2ex_flush),
    .Mem2WbFlush(mem2wb_flush), .JumpFlagToPc(jump_flag_to_pc),
    .JumpAddrToPc(jump_addr_to_pc), .MemTimeout(mem_timeout),
    .StallCnt(stall_cnt), .JumpCnt(jump_cnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_s (
    .Clk(clk), .Rst(rst),
    .IdRs1Addr(id_rs1_addr), .IdRs1Ren(id_rs1_ren),
    .IdRs2Addr(id_rs2_addr), .IdRs2Ren(id_rs2_ren),
    .ExRdAddr(ex_rd_addr), .ExRdWen(ex_rd_wen), .ExIsLoad(ex_is_load),
    .ExJumpFlag(ex_jump_flag), .ExJumpAddr(ex_jump_addr),
    .MemReq(mem_req), .MemAck(mem_ack),
    .PcHold(s_pc_hold), .If2IdHold(s_if2id_hold), .Id2ExHold(s_id2ex_hold),
    .Ex2MemHold(s_ex2mem_hold), .If2IdFlush(s_if2id_flush), .Id2ExFlush(s_id2ex_flush),
    .Mem2WbFlush(s_mem2wb_flush), .JumpFlagToPc(s_jump_flag_to_pc),
    .JumpAddrToPc(s_jump_addr_to_pc), .MemTimeout(s_mem_timeout),
    .StallCnt(s_stall_cnt), .JumpCnt(s_jump_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_idle();
    id_rs1_addr = '0; id_rs1_ren = 1'b0; id_rs2_addr = '0; id_rs2_ren = 1'b0;
    ex_rd_addr = '0; ex_rd_wen = 1'b0; ex_is_load = 1'b0;
    ex_jump_flag = 1'b0; ex_jump_addr = '0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic use_rs2);
    ex_is_load = 1'b1; ex_rd_wen = 1'b1; ex_rd_addr = rd;
    id_rs1_ren = ~use_rs2; id_rs1_addr = use_rs2 ? 5'd0 : 5'd5;
    id_rs2_ren = use_rs2;  id_rs2_addr = use_rs2 ? 5'd5 : 5'd0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    exp_jump  = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_req = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 64'h1234;
    drive_lu(5'd5, 1'b0);
    #1;
    total++;
    if (ctl !== CTL_NONE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_NONE); end
    total++;
    if (jump_addr_to_pc !== 64'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", jump_addr_to_pc); end
    @(posedge clk); #1;
    total++;
    if (stall_cnt !== 32'd0 || jump_cnt !== 32'd0 || mem_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_regs stall=%0d jump=%0d tmo=%b exp=0/0/0", stall_cnt, jump_cnt, mem_timeout);
    end
    total++;
    if (dut.state_q !== RUN) begin bad++; $display("FAIL reset_state got=%0d exp=RUN", dut.state_q); end
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    exp_stall = 0;
    exp_jump  = 0;
  endtask

  task automatic test_load_use();
    logic [7:0] exp_ctl;
    // rs1 match, rd=0, rs2 match, rs1 match with read disabled
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      drive_idle();
      drive_lu((v == 1) ? 5'd0 : 5'd5, (v == 2));
      if (v == 3) id_rs1_ren = 1'b0;
      exp_ctl = (v == 0 || v == 2) ? CTL_LU : CTL_NONE;
      #1;
      total++;
      if (ctl !== exp_ctl) begin bad++; $display("FAIL lu_ctl[%0d] got=%b exp=%b", v, ctl, exp_ctl); end
      if (exp_ctl == CTL_LU) exp_stall++;
      @(posedge clk); #1;
      total++;
      if (stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL lu_stall[%0d] got=%0d exp=%0d", v, stall_cnt, exp_stall); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_jump();
    @(negedge clk);
    drive_lu(5'd5, 1'b0);
    ex_jump_flag = 1'b1;
    ex_jump_addr = 64'h8000_0010;
    #1;
    total++;
    if (ctl !== CTL_JUMP) begin bad++; $display("FAIL jump_ctl got=%b exp=%b", ctl, CTL_JUMP); end
    total++;
    if (jump_addr_to_pc !== 64'h8000_0010) begin bad++; $display("FAIL jump_addr got=%h exp=80000010", jump_addr_to_pc); end
    exp_jump++;
    @(posedge clk); #1;
    total++;
    if (jump_cnt !== 32'(exp_jump) || stall_cnt !== 32'(exp_stall)) begin
      bad++; $display("FAIL jump_cnt jump=%0d stall=%0d exp=%0d/%0d", jump_cnt, stall_cnt, exp_jump, exp_stall);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    // jump, then load-use, then jump again on consecutive cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      drive_lu(5'd5, 1'b1);
      ex_jump_flag = (c != 1);
      ex_jump_addr = 64'h100 + 64'(c);
      #1;
      total++;
      if (ctl !== ((c != 1) ? CTL_JUMP : CTL_LU)) begin bad++; $display("FAIL b2b_ctl[%0d] got=%b", c, ctl); end
      total++;
      if (jump_addr_to_pc !== ((c != 1) ? 64'h100 + 64'(c) : 64'd0)) begin
        bad++; $display("FAIL b2b_addr[%0d] got=%h", c, jump_addr_to_pc);
      end
      if (c != 1) exp_jump++; else exp_stall++;
      @(posedge clk); #1;
    end
    total++;
    if (jump_cnt !== 32'(exp_jump) || stall_cnt !== 32'(exp_stall)) begin
      bad++; $display("FAIL b2b_cnt jump=%0d stall=%0d exp=%0d/%0d", jump_cnt, stall_cnt, exp_jump, exp_stall);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_mem_wait();
    // jump and load-use both present but masked by the wait
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_lu(5'd5, 1'b0);
      ex_jump_flag = 1'b1; ex_jump_addr = 64'hdead;
      mem_req = 1'b1; mem_ack = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_MW || jump_addr_to_pc !== 64'd0) begin
        bad++; $display("FAIL mw_ctl[%0d] got=%b addr=%h exp=%b addr=0", c, ctl, jump_addr_to_pc, CTL_MW);
      end
      exp_stall++;
      @(posedge clk); #1;
      total++;
      if (dut.state_q !== MEM_WAIT) begin bad++; $display("FAIL mw_state[%0d] got=%0d exp=MEM_WAIT", c, dut.state_q); end
    end
    @(negedge clk);
    drive_idle();
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_NONE) begin bad++; $display("FAIL mw_ack_ctl got=%b exp=%b", ctl, CTL_NONE); end
    @(posedge clk); #1;
    total++;
    if (dut.state_q !== RUN) begin bad++; $display("FAIL mw_ack_state got=%0d exp=RUN", dut.state_q); end
    total++;
    if (stall_cnt !== 32'(exp_stall) || jump_cnt !== 32'(exp_jump)) begin
      bad++; $display("FAIL mw_cnt stall=%0d jump=%0d exp=%0d/%0d", stall_cnt, jump_cnt, exp_stall, exp_jump);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_ack = 1'b0;
      #1;
      total++;
      if (s_ctl !== CTL_MW) begin bad++; $display("FAIL tmo_ctl[%0d] got=%b exp=%b", c, s_ctl, CTL_MW); end
      @(posedge clk); #1;
      // cycle 1 enters MEM_WAIT; the 4th MEM_WAIT cycle is cycle 5
      total++;
      if (s_mem_timeout !== (c >= 5)) begin bad++; $display("FAIL tmo_flag[%0d] got=%b exp=%b", c, s_mem_timeout, (c >= 5)); end
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    total++;
    if (s_mem_timeout !== 1'b1 || dut_s.state_q !== RUN) begin
      bad++; $display("FAIL tmo_sticky got=%b state=%0d exp=1 RUN", s_mem_timeout, dut_s.state_q);
    end
    total++;
    if (mem_timeout !== 1'b0) begin bad++; $display("FAIL tmo_default got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_ack = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1;
    ex_jump_flag = 1'b1; ex_jump_addr = 64'h55;
    #1;
    total++;
    if (ctl !== CTL_NONE || s_ctl !== CTL_NONE || jump_addr_to_pc !== 64'd0) begin
      bad++; $display("FAIL rmw_ctl got=%b/%b addr=%h exp=0", ctl, s_ctl, jump_addr_to_pc);
    end
    @(posedge clk); #1;
    total++;
    if (dut.state_q !== RUN || stall_cnt !== 32'd0 || jump_cnt !== 32'd0) begin
      bad++; $display("FAIL rmw_regs state=%0d stall=%0d jump=%0d exp=RUN/0/0", dut.state_q, stall_cnt, jump_cnt);
    end
    total++;
    if (s_mem_timeout !== 1'b0 || s_stall_cnt !== 4'd0) begin
      bad++; $display("FAIL rmw_tmo got=%b stall=%0d exp=0/0", s_mem_timeout, s_stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    exp_stall = 0;
    exp_jump  = 0;
  endtask

  task automatic test_saturation();
    int exp_s;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive_lu(5'd5, 1'b0);
      @(posedge clk); #1;
      exp_s = (i > 15) ? 15 : i;
      total++;
      if (s_stall_cnt !== 4'(exp_s)) begin bad++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", i, s_stall_cnt, exp_s); end
    end
    total++;
    if (stall_cnt !== 32'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      drive_idle();
      ex_jump_flag = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (s_jump_cnt !== 4'd15 || jump_cnt !== 32'd17) begin
      bad++; $display("FAIL sat_jump got=%0d/%0d exp=15/17", s_jump_cnt, jump_cnt);
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_stall = 0;
    exp_jump = 0;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_jump();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
